div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Control stage wrapped around the existing single-cycle-enable integer divider.
- Upstream: accepts one operand pair per transaction on a valid/ready request interface and registers the operands.
- Divider side: screens out divide-by-zero, pulses the divider's enable for exactly one cycle, waits a fixed latency, then captures the quotient.
- Downstream: presents the quotient on a valid/ready response interface that is held until consumed.

Parameters:
- W, 32, data width; must equal the shared DATA_WIDTH definition.
- LATENCY, 1, cycles spent in WAIT after the enable pulse before the quotient is captured; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request operands valid.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_op1  in  W  dividend.
- req_op2  in  W  divisor.
- div_enable  out  1  enable to divider; one-cycle pulse.
- div_op1  out  W  registered dividend driven to divider.
- div_op2  out  W  registered divisor driven to divider.
- div_result  in  W  quotient from divider.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  W  quotient, or all-ones on divide-by-zero.
- rsp_div_zero  out  1  response came from a zero divisor.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sampled at a rising edge):
  - state = IDLE, counter = 0.
  - div_enable, rsp_valid, rsp_div_zero, div_op1, div_op2, rsp_result all = 0.
  - Reset overrides all other events, including mid-ISSUE/WAIT/DONE: the transaction is aborted and no response is produced.
- State machine, 2-bit encoding: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready = 1. When req_valid & req_ready at an edge, latch req_op1 into div_op1 and req_op2 into div_op2.
  - If req_op2 == 0: go to DONE; load rsp_result = all ones and rsp_div_zero = 1. No divider enable is issued.
  - Otherwise: go to ISSUE.
- ISSUE: exactly one cycle. div_enable = 1 (registered output, high only during this cycle). Load counter = LATENCY. Go to WAIT.
- WAIT: div_enable = 0. Counter decrements each cycle.
  - At the edge where counter == 1: capture div_result into rsp_result, clear rsp_div_zero, go to DONE.
- DONE: rsp_valid = 1.
  - rsp_result and rsp_div_zero are stable while rsp_valid is high.
  - When rsp_ready is high at an edge: go to IDLE.
  - req_ready = 0, so no new request is accepted in the same cycle as the response handshake.
- Latency, request handshake edge to first rsp_valid cycle:
  - LATENCY + 2 cycles for a nonzero divisor (3 at default).
  - 1 cycle for a zero divisor.
- div_op1 and div_op2 hold their values from acceptance until the next acceptance. They are stable throughout ISSUE and WAIT.
- rsp_result holds its value after the response handshake until the next capture.
- Paths:
  - No combinational path from req_* to rsp_*.
  - No combinational path from rsp_ready to req_ready.
  - req_ready and busy are decoded from state only.
- Division is unsigned; width handling is the divider's responsibility. The sequencer does no arithmetic beyond the zero compare.
- req_op1/req_op2 are ignored when no handshake occurs.
- rsp_ready outside DONE is ignored.

Decomposition:
- Shared include (div_defs.v, alongside the width definitions):
  - state encodings DIV_IDLE / DIV_ISSUE / DIV_WAIT / DIV_DONE.
  - DIV_ZERO_RESULT constant (all ones of DATA_WIDTH).
- No sub-module. The 4-bit latency counter is inline.
- The divider is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle: hold reset 2 cycles -> req_ready = 1, busy = 0, rsp_valid = 0, div_enable = 0, all data outputs 0.
- Basic divide, LATENCY = 1: op1 = 100, op2 = 7 handshake at edge T -> div_enable high only in cycle T+1; rsp_valid at T+3 with rsp_result = 14, rsp_div_zero = 0.
- Divide by zero: op1 = 55, op2 = 0 -> rsp_valid the next cycle, rsp_result = 0xFFFFFFFF, rsp_div_zero = 1, div_enable never asserts.
- Response backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_valid and rsp_result = 14 stable throughout, req_ready = 0; rsp_ready high -> IDLE next cycle.
- Reset mid-op: assert reset during WAIT of op1 = 9, op2 = 3 -> IDLE next cycle, rsp_valid never asserts. A following request 8/2 then returns 4 normally.
- LATENCY = 3, back-to-back: 1000/10 then 7/7 -> div_enable pulses exactly once per transaction; rsp_valid 5 cycles after each acceptance; results 100 then 1.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider control stage: data width, FSM state codes
// and the quotient reported for a zero divisor.
package div_sequencer_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_ISSUE = 2'd1,
    DIV_WAIT  = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_RESULT = '1;

endpackage

// File: rtl/div_sequencer.sv
// Control stage around an external enable-pulsed divider; zero divisors are
// answered directly, otherwise pulse enable, wait LATENCY cycles, capture.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int W       = DATA_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_op1,
  input  logic [W-1:0] req_op2,
  output logic         div_enable,
  output logic [W-1:0] div_op1,
  output logic [W-1:0] div_op2,
  input  logic [W-1:0] div_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_div_zero,
  output logic         busy
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  div_state_e state;
  logic [3:0] count;

  // Handshake-facing status depends on state alone, keeping rsp_ready off req_ready.
  assign req_ready = (state == DIV_IDLE);
  assign busy      = (state != DIV_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= DIV_IDLE;
      count        <= 4'd0;
      div_enable   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_div_zero <= 1'b0;
      div_op1      <= '0;
      div_op2      <= '0;
      rsp_result   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (req_valid) begin
            div_op1 <= req_op1;
            div_op2 <= req_op2;
            if (req_op2 == '0) begin
              rsp_result   <= W'(DIV_ZERO_RESULT);
              rsp_div_zero <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= DIV_DONE;
            end else begin
              div_enable <= 1'b1;
              state      <= DIV_ISSUE;
            end
          end
        end
        DIV_ISSUE: begin
          div_enable <= 1'b0;
          count      <= LAT;
          state      <= DIV_WAIT;
        end
        DIV_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            rsp_result   <= div_result;
            rsp_div_zero <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench: two sequencers (LATENCY 1 and 3) each driving a behavioural
// divider; expected quotients and arrival cycles are queued at request time.
module tb_div_sequencer;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        rsp_ready_a = 1'b1, rsp_ready_b = 1'b1;
  logic [31:0] req_op1_a = '0, req_op2_a = '0, req_op1_b = '0, req_op2_b = '0;
  logic [31:0] div_result_a = '0, div_result_b = '0;
  logic        req_ready_a, req_ready_b, div_enable_a, div_enable_b;
  logic        rsp_valid_a, rsp_valid_b, rsp_div_zero_a, rsp_div_zero_b;
  logic        busy_a, busy_b;
  logic [31:0] div_op1_a, div_op2_a, div_op1_b, div_op2_b;
  logic [31:0] rsp_result_a, rsp_result_b;

  div_sequencer #(.W(32), .LATENCY(1)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_op1(req_op1_a), .req_op2(req_op2_a),
    .div_enable(div_enable_a), .div_op1(div_op1_a), .div_op2(div_op2_a),
    .div_result(div_result_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_result(rsp_result_a), .rsp_div_zero(rsp_div_zero_a),
    .busy(busy_a)
  );

  div_sequencer #(.W(32), .LATENCY(3)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_op1(req_op1_b), .req_op2(req_op2_b),
    .div_enable(div_enable_b), .div_op1(div_op1_b), .div_op2(div_op2_b),
    .div_result(div_result_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_result(rsp_result_b), .rsp_div_zero(rsp_div_zero_b),
    .busy(busy_b)
  );

  // Behavioural dividers: quotient is ready the cycle after the enable pulse.
  always @(posedge clock) begin
    if (div_enable_a) div_result_a <= (div_op2_a == 0) ? '1 : div_op1_a / div_op2_a;
    if (div_enable_b) div_result_b <= (div_op2_b == 0) ? '1 : div_op1_b / div_op2_b;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t q_a[$], q_b[$];
  exp_t xa, xb;
  logic pv_a = 1'b0, pv_b = 1'b0;
  int   en_cnt_a = 0, en_cnt_b = 0, en_last_a = -1;

  // Monitors: each rising rsp_valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (div_enable_a) begin en_cnt_a <= en_cnt_a + 1; en_last_a <= cyc; end
    if (div_enable_b) en_cnt_b <= en_cnt_b + 1;
    if (rsp_valid_a && !pv_a) begin
      if (q_a.size() == 0) chk("a unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        xa = q_a.pop_front();
        chk("a rsp_result", rsp_result_a, xa.res);
        chk("a rsp_div_zero", {31'd0, rsp_div_zero_a}, {31'd0, xa.zero});
        chk("a rsp cycle", 32'(cyc), 32'(xa.due));
      end
    end
    if (rsp_valid_b && !pv_b) begin
      if (q_b.size() == 0) chk("b unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        xb = q_b.pop_front();
        chk("b rsp_result", rsp_result_b, xb.res);
        chk("b rsp_div_zero", {31'd0, rsp_div_zero_b}, {31'd0, xb.zero});
        chk("b rsp cycle", 32'(cyc), 32'(xb.due));
      end
    end
    pv_a <= rsp_valid_a;
    pv_b <= rsp_valid_b;
  end

  // Issues one request on instance sel; returns the handshake edge number in e.
  task automatic send(input bit sel, input logic [31:0] o1, input logic [31:0] o2,
                      input logic [31:0] res, input logic z, input bit push, output int e);
    int   n = 0;
    int   lat;
    exp_t x;
    while (!(sel ? req_ready_b : req_ready_a) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("req_ready timeout", 32'd0, 32'd1);
    if (sel) begin req_valid_b = 1'b1; req_op1_b = o1; req_op2_b = o2; end
    else     begin req_valid_a = 1'b1; req_op1_a = o1; req_op2_a = o2; end
    e   = cyc + 1;
    lat = z ? 1 : (sel ? 3 : 1) + 2;
    x   = '{res, z, e + lat - 1};
    if (push) begin
      if (sel) q_b.push_back(x);
      else     q_a.push_back(x);
    end
    @(negedge clock);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while (((sel ? q_b.size() : q_a.size()) != 0 || !(sel ? req_ready_b : req_ready_a)) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("drain timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, e2, en0, n;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset req_ready", {31'd0, req_ready_a}, 32'd1);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("reset div_enable", {31'd0, div_enable_a}, 32'd0);
    chk("reset div_op1", div_op1_a, 32'd0);
    chk("reset div_op2", div_op2_a, 32'd0);
    chk("reset rsp_result", rsp_result_a, 32'd0);
    chk("reset rsp_div_zero", {31'd0, rsp_div_zero_a}, 32'd0);
    chk("reset b req_ready", {31'd0, req_ready_b}, 32'd1);

    // 100/7 with LATENCY 1
    en0 = en_cnt_a;
    send(1'b0, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, e);
    chk("basic div_op1 held", div_op1_a, 32'd100);
    chk("basic div_op2 held", div_op2_a, 32'd7);
    drain(1'b0);
    chk("basic enable count", 32'(en_cnt_a - en0), 32'd1);
    chk("basic enable cycle", 32'(en_last_a), 32'(e));

    // Zero divisor: immediate all-ones answer, no enable
    en0 = en_cnt_a;
    send(1'b0, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, e);
    drain(1'b0);
    chk("zero enable count", 32'(en_cnt_a - en0), 32'd0);

    // Response backpressure for 5 cycles
    rsp_ready_a = 1'b0;
    send(1'b0, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, e);
    n = 0;
    while (!rsp_valid_a && n < 20) begin @(negedge clock); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
      chk("bp rsp_result", rsp_result_a, 32'd14);
      chk("bp req_ready", {31'd0, req_ready_a}, 32'd0);
      @(negedge clock);
    end
    rsp_ready_a = 1'b1;
    @(negedge clock);
    chk("bp release req_ready", {31'd0, req_ready_a}, 32'd1);
    chk("bp release rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("bp rsp_result held", rsp_result_a, 32'd14);

    // Reset during WAIT aborts 9/3 without a response
    send(1'b0, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, e);
    @(negedge clock);
    chk("abort busy in WAIT", {31'd0, busy_a}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort req_ready", {31'd0, req_ready_a}, 32'd1);
    chk("abort rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("abort rsp_result", rsp_result_a, 32'd0);
    repeat (4) @(negedge clock);
    chk("abort still idle", {31'd0, rsp_valid_a}, 32'd0);
    send(1'b0, 32'd8, 32'd2, 32'd4, 1'b0, 1'b1, e);
    drain(1'b0);

    // LATENCY 3, back-to-back
    en0 = en_cnt_b;
    send(1'b1, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1, e);
    send(1'b1, 32'd7, 32'd7, 32'd1, 1'b0, 1'b1, e2);
    drain(1'b1);
    chk("b enable count", 32'(en_cnt_b - en0), 32'd2);
    chk("b second accept after first", {31'd0, e2 > e + 5}, 32'd1);

    repeat (3) @(negedge clock);
    chk("a queue empty", 32'(q_a.size()), 32'd0);
    chk("b queue empty", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
